// File: rtl/req_encoder_8to3_pkg.sv
// Shared sizing defaults and FSM state type for the request encoder.
package enc_pkg;
  localparam int unsigned N_REQ_DEF = 8;
  localparam int unsigned IDX_W_DEF = 3;

  typedef enum logic {
    ENC_IDLE    = 1'b0,
    ENC_PRESENT = 1'b1
  } enc_state_t;
endpackage

// File: rtl/req_encoder_8to3_rr_pick.sv
// Combinational masked priority picker: lowest set bit at/above ptr, else lowest overall.
module rr_pick #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned IDX_W = $clog2(N_REQ),
  parameter int unsigned RR    = 0
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [N_REQ-1:0] masked;
  logic [IDX_W-1:0] lo_all;
  logic [IDX_W-1:0] lo_masked;

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    masked    = '0;
    lo_all    = '0;
    lo_masked = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (RR != 0 && IDX_W'(i) >= ptr) masked[i] = cand[i];
      if (cand[i])   lo_all    = IDX_W'(i);
      if (masked[i]) lo_masked = IDX_W'(i);
    end
    win_vld = |cand;
    win_idx = (|masked) ? lo_masked : lo_all;
  end

endmodule

// File: rtl/req_encoder_8to3.sv
// Sequential request encoder: latches request pulses and presents one index per valid/ready transfer.
module req_encoder_8to3
  import enc_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = $clog2(N_REQ),
  parameter int unsigned RR    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [N_REQ-1:0] pending_o,
  output logic             drop_o
);

  enc_state_t       state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             drop_q, drop_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             hs;
  logic             load;

  assign cand   = pending_q | req_i;
  assign win_oh = N_REQ'(1) << win_idx;
  assign hs     = (state_q == ENC_PRESENT) && ready_i;
  assign load   = win_vld && ((state_q == ENC_IDLE) || hs);

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W),
    .RR    (RR)
  ) u_pick (
    .cand    (cand),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ENC_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
    end
  end

  // Without a load every request folds into pending; a load removes only the winner.
  always_comb begin
    state_d   = state_q;
    pending_d = cand;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    drop_d    = |(req_i & pending_q);

    case (state_q)
      ENC_IDLE:    if (win_vld) state_d = ENC_PRESENT;
      ENC_PRESENT: if (ready_i && !win_vld) state_d = ENC_IDLE;
      default:     state_d = ENC_IDLE;
    endcase

    if (load) begin
      idx_d     = win_idx;
      ptr_d     = win_idx + IDX_W'(1);
      pending_d = cand & ~win_oh;
      drop_d    = |(req_i & pending_q & ~win_oh);
    end
  end

  assign idx_o     = idx_q;
  assign valid_o   = (state_q == ENC_PRESENT);
  assign pending_o = pending_q;
  assign drop_o    = drop_q;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;

  logic [2:0] idx_f, idx_r;
  logic       valid_f, valid_r, drop_f, drop_r;
  logic [7:0] pend_f, pend_r;

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = fixed priority, 1 = round-robin.
  logic [7:0] m_pend [2];
  int         m_ptr  [2];
  int         m_idx  [2];
  logic       m_valid[2];
  logic       m_drop [2];

  always #5 clk = ~clk;

  req_encoder_8to3 #(.N_REQ(8), .IDX_W(3), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_i(req), .idx_o(idx_f), .valid_o(valid_f),
    .ready_i(ready), .pending_o(pend_f), .drop_o(drop_f)
  );

  req_encoder_8to3 #(.N_REQ(8), .IDX_W(3), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_i(req), .idx_o(idx_r), .valid_o(valid_r),
    .ready_i(ready), .pending_o(pend_r), .drop_o(drop_r)
  );

  // First set bit of c scanning upward from start, wrapping modulo 8.
  function automatic int pick(input logic [7:0] c, input int start);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (start + k) % 8;
      if (c[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = 8'h00;
      m_ptr[m]   = 0;
      m_idx[m]   = 0;
      m_valid[m] = 1'b0;
      m_drop[m]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic rdy);
    for (int m = 0; m < 2; m++) begin
      logic [7:0] c;
      logic [7:0] wbit;
      int         w;
      c = m_pend[m] | r;
      if (!m_valid[m] || rdy) begin
        if (c != 8'h00) begin
          w          = pick(c, (m == 1) ? m_ptr[m] : 0);
          wbit       = 8'h00;
          wbit[w]    = 1'b1;
          m_drop[m]  = ((r & m_pend[m] & ~wbit) != 8'h00);
          m_pend[m]  = c & ~wbit;
          m_idx[m]   = w;
          m_ptr[m]   = (w + 1) % 8;
          m_valid[m] = 1'b1;
        end else begin
          m_drop[m]  = 1'b0;
          m_valid[m] = 1'b0;
        end
      end else begin
        m_drop[m] = ((r & m_pend[m]) != 8'h00);
        m_pend[m] = c;
      end
    end
  endtask

  // Advance one clock; inputs are stable across the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step(req, ready);
    #1;
  endtask

  task automatic idle(input int n);
    req   = 8'h00;
    ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    ready = 1'b0;
    model_reset();
    #3;
    total++;
    if ({valid_f, idx_f, pend_f, drop_f, valid_r, idx_r, pend_r, drop_r} !== 26'd0) begin
      bad++;
      $display("FAIL reset_state fp v=%0b i=%0d p=%h d=%0b rr v=%0b i=%0d p=%h d=%0b want all 0",
               valid_f, idx_f, pend_f, drop_f, valid_r, idx_r, pend_r, drop_r);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    ready = 1'b1;
    req   = 8'b0000_0100;
    cycle();
    req = 8'h00;
    total++;
    if (valid_f !== 1'b1 || idx_f !== 3'd2 || pend_f !== 8'h00) begin
      bad++;
      $display("FAIL single_present v=%0b i=%0d p=%h want 1 2 00", valid_f, idx_f, pend_f);
    end
    cycle();
    total++;
    if (valid_f !== 1'b0) begin
      bad++;
      $display("FAIL single_idle v=%0b want 0", valid_f);
    end
  endtask

  task automatic test_fixed_seq();
    int exp_idx[3] = '{1, 4, 7};
    idle(2);
    req = 8'b1001_0010;
    cycle();
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid_f !== 1'b1 || idx_f !== 3'(exp_idx[i])) begin
        bad++;
        $display("FAIL fixed_seq[%0d] v=%0b i=%0d want 1 %0d", i, valid_f, idx_f, exp_idx[i]);
      end
      cycle();
    end
    total++;
    if (valid_f !== 1'b0) begin
      bad++;
      $display("FAIL fixed_seq_idle v=%0b want 0", valid_f);
    end
  endtask

  task automatic test_rr();
    int exp_idx[4] = '{4, 0, 1, 0};
    idle(2);
    req = 8'b0000_0001;
    cycle();
    req = 8'b0001_0001;
    cycle();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (valid_r !== 1'b1 || idx_r !== 3'(exp_idx[i])) begin
        bad++;
        $display("FAIL rr_seq[%0d] v=%0b i=%0d want 1 %0d", i, valid_r, idx_r, exp_idx[i]);
      end
      req = (i == 1) ? 8'b0000_0011 : 8'h00;
      cycle();
    end
    total++;
    if (valid_r !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle v=%0b want 0", valid_r);
    end
  endtask

  task automatic test_stall();
    logic [7:0] seq_req[5]  = '{8'h08, 8'h08, 8'h00, 8'h08, 8'h00};
    logic       seq_drop[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    idle(2);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = seq_req[i];
      cycle();
      total++;
      if (valid_f !== 1'b1 || idx_f !== 3'd3 || drop_f !== seq_drop[i] ||
          (i > 0 && pend_f !== 8'h08)) begin
        bad++;
        $display("FAIL stall[%0d] v=%0b i=%0d d=%0b p=%h want 1 3 %0b 08",
                 i, valid_f, idx_f, drop_f, pend_f, seq_drop[i]);
      end
    end
    ready = 1'b1;
    cycle();
    total++;
    if (valid_f !== 1'b1 || idx_f !== 3'd3 || pend_f !== 8'h00) begin
      bad++;
      $display("FAIL stall_replay v=%0b i=%0d p=%h want 1 3 00", valid_f, idx_f, pend_f);
    end
    cycle();
    total++;
    if (valid_f !== 1'b0) begin
      bad++;
      $display("FAIL stall_idle v=%0b want 0", valid_f);
    end
  endtask

  task automatic test_async_reset();
    idle(2);
    ready = 1'b0;
    req   = 8'hF1;
    cycle();
    req = 8'h00;
    total++;
    if (valid_f !== 1'b1 || idx_f !== 3'd0 || pend_f !== 8'hF0) begin
      bad++;
      $display("FAIL areset_setup v=%0b i=%0d p=%h want 1 0 f0", valid_f, idx_f, pend_f);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({valid_f, idx_f, pend_f, drop_f, valid_r, idx_r, pend_r, drop_r} !== 26'd0) begin
      bad++;
      $display("FAIL areset_clear fp v=%0b i=%0d p=%h rr v=%0b i=%0d p=%h want all 0",
               valid_f, idx_f, pend_f, valid_r, idx_r, pend_r);
    end
    cycle();
    rst_n = 1'b1;
    ready = 1'b1;
    cycle();
    cycle();
    total++;
    if (valid_f !== 1'b0 || valid_r !== 1'b0 || pend_f !== 8'h00 || pend_r !== 8'h00) begin
      bad++;
      $display("FAIL areset_after v=%0b/%0b p=%h/%h want 0 0 00 00", valid_f, valid_r, pend_f, pend_r);
    end
  endtask

  task automatic test_simultaneous();
    idle(2);
    req = 8'b0100_0000;
    cycle();
    total++;
    if (valid_f !== 1'b1 || idx_f !== 3'd6) begin
      bad++;
      $display("FAIL simul_setup v=%0b i=%0d want 1 6", valid_f, idx_f);
    end
    req = 8'b0100_0001;
    cycle();
    req = 8'h00;
    total++;
    if (valid_f !== 1'b1 || idx_f !== 3'd0 || pend_f !== 8'h40 || drop_f !== 1'b0) begin
      bad++;
      $display("FAIL simul_first v=%0b i=%0d p=%h d=%0b want 1 0 40 0", valid_f, idx_f, pend_f, drop_f);
    end
    cycle();
    total++;
    if (valid_f !== 1'b1 || idx_f !== 3'd6) begin
      bad++;
      $display("FAIL simul_second v=%0b i=%0d want 1 6", valid_f, idx_f);
    end
    cycle();
    total++;
    if (valid_f !== 1'b0) begin
      bad++;
      $display("FAIL simul_idle v=%0b want 0", valid_f);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      req   = 8'($urandom & $urandom & $urandom);
      ready = ($urandom_range(0, 3) != 0);
      cycle();
      total++;
      if (valid_f !== m_valid[0] || idx_f !== 3'(m_idx[0]) || pend_f !== m_pend[0] ||
          drop_f !== m_drop[0]) begin
        bad++;
        $display("FAIL random_fp[%0d] v=%0b i=%0d p=%h d=%0b want %0b %0d %h %0b",
                 n, valid_f, idx_f, pend_f, drop_f, m_valid[0], m_idx[0], m_pend[0], m_drop[0]);
      end
      total++;
      if (valid_r !== m_valid[1] || idx_r !== 3'(m_idx[1]) || pend_r !== m_pend[1] ||
          drop_r !== m_drop[1]) begin
        bad++;
        $display("FAIL random_rr[%0d] v=%0b i=%0d p=%h d=%0b want %0b %0d %h %0b",
                 n, valid_r, idx_r, pend_r, drop_r, m_valid[1], m_idx[1], m_pend[1], m_drop[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_seq();
    test_rr();
    test_stall();
    test_async_reset();
    test_simultaneous();
    test_random();
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
